// File: rtl/shift_sched_pkg.sv
// Shared definitions for the shift scheduler.
//   - Default data and shift-amount widths.
//   - Operation codes presented on reqN_op.
//   - FSM state encoding used by shift_sched.
package shift_sched_pkg;

  localparam int unsigned WidthDefault = 16;
  localparam int unsigned ShwDefault   = 4;

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpRol = 2'b10;
  localparam logic [1:0] OpRor = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StP1   = 2'b01,
    StP2   = 2'b10,
    StResp = 2'b11
  } state_e;

endpackage

// File: rtl/shift_left_core.sv
// Purely combinational left barrel shifter with zero fill.
// Ports:
//   din  - operand, WIDTH bits
//   amt  - shift amount, SHW bits (taken modulo WIDTH by construction)
//   dout - din shifted left by amt, vacated bits filled with zero
module shift_left_core #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] dout
);

  assign dout = din << amt;

endmodule

// File: rtl/shift_sched.sv
// Two-requester shift/rotate scheduler sharing one left barrel shifter.
// One transaction is in flight at a time. SLL and SRL finish in one shifter pass (P1);
// rotates need a second pass (P2) that ORs in the wrapped-around part.
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   reqN_valid/ready                 - request handshake for requester N (0, 1)
//   reqN_data/amt/op                 - operand, shift amount, op code (SLL/SRL/ROL/ROR)
//   rsp_valid/ready                  - response handshake
//   rsp_data, rsp_id                 - result and owning requester index
//   busy                             - high whenever the FSM is not idle
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault,
  parameter int unsigned SHW   = ShwDefault
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [SHW-1:0]   req0_amt,
  input  logic [1:0]       req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [SHW-1:0]   req1_amt,
  input  logic [1:0]       req1_op,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,

  output logic             busy
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   amt_q, amt_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic             grant;
  logic             accept;
  logic [SHW-1:0]   rot_amt;
  logic [WIDTH-1:0] sh_in;
  logic [SHW-1:0]   sh_amt;
  logic [WIDTH-1:0] sh_out;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  // Round-robin arbitration: the pointer only matters when both requesters are valid.
  // With a single valid, grant follows req1_valid, which picks whichever one is asking.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ptr_q;
    end else begin
      grant = req1_valid;
    end
  end

  // Reset is folded in so that no ready is shown while the block is being cleared.
  assign accept     = rst_n && (state_q == StIdle) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept &&  grant;

  // ROR by n is ROL by (WIDTH - n) mod WIDTH; SHW-bit negation gives exactly that.
  assign rot_amt = (op_q == OpRor) ? SHW'(-amt_q) : amt_q;

  // Shifter operand selection. SRL is a left shift of the bit-reversed operand, which
  // is also how P2 builds the right-shifted wrap-around part of a rotate.
  always_comb begin
    sh_in  = data_q;
    sh_amt = amt_q;
    case (state_q)
      StP1: begin
        if (op_q == OpSrl) begin
          sh_in = bit_rev(data_q);
        end
        if (op_q[1]) begin
          sh_amt = rot_amt;
        end
      end
      StP2: begin
        sh_in  = bit_rev(data_q);
        sh_amt = SHW'(-rot_amt);
      end
      default: ;
    endcase
  end

  shift_left_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift_left_core (
    .din  (sh_in),
    .amt  (sh_amt),
    .dout (sh_out)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    amt_d   = amt_q;
    op_d    = op_q;
    id_d    = id_q;
    res_d   = res_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StP1;
          ptr_d   = ~grant;
          id_d    = grant;
          data_d  = grant ? req1_data : req0_data;
          amt_d   = grant ? req1_amt  : req0_amt;
          op_d    = grant ? req1_op   : req0_op;
        end
      end
      StP1: begin
        res_d   = (op_q == OpSrl) ? bit_rev(sh_out) : sh_out;
        state_d = op_q[1] ? StP2 : StResp;
      end
      StP2: begin
        // A zero rotate has no wrapped part; the reversed shift by 0 would echo data.
        if (rot_amt != '0) begin
          res_d = res_q | bit_rev(sh_out);
        end
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      id_q    <= id_d;
      res_q   <= res_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = res_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != StIdle);

endmodule
